rv16r_print_tx: RTL and testbench

Serial transmitter for the rv16r print-register outputs. It snapshots the three 16-bit print buses and sends each changed snapshot off-chip as a framed 8N1 UART byte stream. This moves register observation from simulation-only waveform dumps to a single pin on hardware. It sits beside `rv16r` at the top level, on the same clock and reset, and consumes `printRegOneData`, `printRegTwoData` and `printRegThreeData`.

---
 rtl/rv16r_print_pkg.sv | 49 ++++
 rtl/rv16r_print_tx_uart.sv | 110 +++++++++++
 rtl/rv16r_print_tx.sv | 95 +++++++++
 tb/tb_rv16r_print_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16r_print_pkg.sv
// -----------------------------------------------------------------------------
// rv16r_print_pkg
// Shared definitions for the rv16r print-register UART transmitter:
//   PRINT_SYNC_BYTE    - first byte of every frame
//   PRINT_FRAME_BYTES  - bytes per frame (sync + 6 data + checksum)
//   printTxState_t     - byte-level UART transmitter states
//   printChecksum()    - XOR of the six data bytes of a 48-bit snapshot
//   printFrameByte()   - selects byte N of a frame (0 = sync, 7 = checksum)
// -----------------------------------------------------------------------------
package rv16r_print_pkg;

    localparam logic [7:0] PRINT_SYNC_BYTE   = 8'hA5;
    localparam int         PRINT_FRAME_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } printTxState_t;

    // Snapshot layout is {R1, R2, R3}, so byte 0 of the data is R1[15:8].
    function automatic logic [7:0] printChecksum(input logic [47:0] snap);
        logic [7:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            sum = sum ^ snap[47 - 8 * i -: 8];
        end
        return sum;
    endfunction

    function automatic logic [7:0] printFrameByte(input logic [47:0] snap,
                                                  input logic [7:0]  csum,
                                                  input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = PRINT_SYNC_BYTE;
            3'd1:    b = snap[47:40];
            3'd2:    b = snap[39:32];
            3'd3:    b = snap[31:24];
            3'd4:    b = snap[23:16];
            3'd5:    b = snap[15:8];
            3'd6:    b = snap[7:0];
            default: b = csum;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rv16r_print_tx_uart.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// 8N1 byte serializer. One start bit (0), eight data bits LSB first, one stop
// bit (1); every bit lasts CLKS_PER_BIT clocks.
//   clk, rst    - clock, synchronous active-high reset
//   txByte      - byte to send, taken when byteValid && byteReady
//   byteValid   - a byte is offered
//   byteReady   - high in IDLE and in the last cycle of the stop bit, so a
//                 byte offered continuously follows the previous one with no gap
//   tx          - serial line, registered, idles high
// -----------------------------------------------------------------------------
module uart_byte_tx
    import rv16r_print_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txByte,
    input  logic       byteValid,
    output logic       byteReady,
    output logic       tx
);

    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    printTxState_t      state, stateNext;
    logic [TIMER_W-1:0] timer, timerNext;
    logic [2:0]         bitIdx, bitIdxNext;
    logic [7:0]         shiftReg, shiftNext;
    logic               txNext;
    logic               bitDone;

    assign bitDone = (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= stateNext;
            timer    <= timerNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            tx       <= txNext;
        end
    end

    always_comb begin
        stateNext  = state;
        timerNext  = bitDone ? '0 : timer + 1'b1;
        bitIdxNext = bitIdx;
        shiftNext  = shiftReg;
        txNext     = tx;
        byteReady  = 1'b0;

        case (state)
            IDLE: begin
                timerNext = '0;
                byteReady = 1'b1;
                if (byteValid) begin
                    stateNext = START;
                    shiftNext = txByte;
                    txNext    = 1'b0;
                end
            end
            START: begin
                if (bitDone) begin
                    stateNext  = DATA;
                    bitIdxNext = '0;
                    txNext     = shiftReg[0];
                end
            end
            DATA: begin
                if (bitDone) begin
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                        shiftNext  = shiftReg >> 1;
                        txNext     = shiftReg[1];
                    end
                end
            end
            STOP: begin
                byteReady = bitDone;
                if (bitDone) begin
                    // Chain straight into the next start bit when a byte waits.
                    if (byteValid) begin
                        stateNext = START;
                        shiftNext = txByte;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv16r_print_tx.sv
// -----------------------------------------------------------------------------
// rv16r_print_tx
// Snapshots the three rv16r print registers and sends each changed (or forced)
// snapshot as an 8-byte UART frame: A5, R1 hi/lo, R2 hi/lo, R3 hi/lo, XOR.
//   clk, rst            - clock, synchronous active-high reset
//   printRegOneData     - print register 1
//   printRegTwoData     - print register 2
//   printRegThreeData   - print register 3
//   printForce          - send current snapshot even if unchanged (IDLE only)
//   tx                  - UART line, idles high
//   busy                - high for the whole 80-bit frame
//   frameCount          - completed frames, wraps at 256
// -----------------------------------------------------------------------------
module rv16r_print_tx
    import rv16r_print_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] printRegOneData,
    input  logic [15:0] printRegTwoData,
    input  logic [15:0] printRegThreeData,
    input  logic        printForce,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  frameCount
);

    localparam logic [2:0] LAST_BYTE = 3'(PRINT_FRAME_BYTES - 1);

    logic [47:0] snapshot;
    logic [47:0] lastSent;
    logic [47:0] frameBuf;
    logic [7:0]  checksum;
    logic [2:0]  byteIdx;
    logic        trigger;
    logic        byteValid;
    logic        byteReady;
    logic [7:0]  txByte;

    assign snapshot = {printRegOneData, printRegTwoData, printRegThreeData};
    assign trigger  = !busy && ((snapshot != lastSent) || printForce);

    // The sync byte is offered in the trigger cycle itself so the serializer
    // registers the start bit on the same edge that raises busy. While busy,
    // the byte after the one in flight is offered until the checksum has gone.
    always_comb begin
        byteValid = 1'b0;
        txByte    = PRINT_SYNC_BYTE;
        if (busy) begin
            byteValid = (byteIdx != LAST_BYTE);
            txByte    = printFrameByte(frameBuf, checksum, byteIdx + 3'd1);
        end else begin
            byteValid = trigger;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            byteIdx    <= '0;
            frameCount <= '0;
            lastSent   <= '0;
            frameBuf   <= '0;
            checksum   <= '0;
        end else if (trigger) begin
            busy     <= 1'b1;
            byteIdx  <= '0;
            frameBuf <= snapshot;
            lastSent <= snapshot;
            checksum <= printChecksum(snapshot);
        end else if (busy && byteReady) begin
            // byteReady while busy marks the final cycle of a stop bit.
            if (byteIdx == LAST_BYTE) begin
                busy       <= 1'b0;
                frameCount <= frameCount + 8'd1;
            end else begin
                byteIdx <= byteIdx + 3'd1;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uByteTx (
        .clk      (clk),
        .rst      (rst),
        .txByte   (txByte),
        .byteValid(byteValid),
        .byteReady(byteReady),
        .tx       (tx)
    );

endmodule

// File: tb/tb_rv16r_print_tx.sv
// -----------------------------------------------------------------------------
// tb_rv16r_print_tx
// Three instances (CLKS_PER_BIT = 2, 4, 16) share the print inputs. Each lane
// has a frame-level reference model that predicts the line waveform, busy and
// frameCount every cycle and queues expected frames; a separate decoder turns
// the tx line back into bytes and checks them against that queue.
// -----------------------------------------------------------------------------
module tb_rv16r_print_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] r1, r2, r3;
    logic        printForce;
    logic [2:0]  holdForce;

    int cmpCount  = 0;
    int failCount = 0;
    int cyc       = 0;

    typedef struct {
        logic [63:0] bytes;
        int          start;
    } frame_t;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int C = (g == 0) ? 2 : ((g == 1) ? 4 : 16);
        localparam int FRAME_CYC = 80 * C;

        logic       txL, busyL, forceL;
        logic [7:0] fcL;
        frame_t     expQ[$];
        bit         mBusy;

        assign forceL = printForce | holdForce[g];

        rv16r_print_tx #(.CLKS_PER_BIT(C)) dut (
            .clk              (clk),
            .rst              (rst),
            .printRegOneData  (r1),
            .printRegTwoData  (r2),
            .printRegThreeData(r3),
            .printForce       (forceL),
            .tx               (txL),
            .busy             (busyL),
            .frameCount       (fcL)
        );

        function automatic logic [63:0] buildFrame(input logic [47:0] s);
            logic [7:0]  d;
            logic [7:0]  cs;
            logic [63:0] f;
            cs = 8'h00;
            f  = '0;
            f[7:0] = 8'hA5;
            for (int i = 0; i < 6; i++) begin
                d = s[47 - 8 * i -: 8];
                cs = cs ^ d;
                f[8 * (i + 1) +: 8] = d;
            end
            f[63:56] = cs;
            return f;
        endfunction

        // Reference model: frame timing from the trigger rule and bit counts.
        initial begin : model
            int          remaining;
            int          pos, bi, by, bb;
            int          segErr, firstBad;
            logic [47:0] mLast;
            logic [7:0]  mCount;
            logic [63:0] curFrame;
            logic        exTx;
            bit          boundary, frameEnd;
            remaining = 0; segErr = 0; firstBad = 0;
            mLast = '0; mCount = '0; curFrame = '0;
            mBusy = 0;
            forever begin
                @(posedge clk);
                boundary = 0;
                frameEnd = 0;
                if (rst) begin
                    boundary  = 1;
                    remaining = 0;
                    mLast     = '0;
                    mCount    = '0;
                    expQ.delete();
                end else if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) begin
                        mCount   = mCount + 8'd1;
                        frameEnd = 1;
                        boundary = 1;
                    end
                end else if (({r1, r2, r3} != mLast) || forceL) begin
                    boundary  = 1;
                    mLast     = {r1, r2, r3};
                    curFrame  = buildFrame(mLast);
                    remaining = FRAME_CYC;
                    expQ.push_back('{curFrame, cyc});
                end
                mBusy = (remaining > 0);
                #1;
                if (boundary) begin
                    check($sformatf("lane%0d waveform segment (bad cycles, first at %0d)", g, firstBad),
                          64'(segErr), 64'd0);
                    segErr = 0;
                end
                if (frameEnd) check($sformatf("lane%0d frameCount at frame end", g), 64'(fcL), 64'(mCount));
                exTx = 1'b1;
                if (remaining > 0) begin
                    pos = FRAME_CYC - remaining;
                    bi  = pos / C;
                    by  = bi / 10;
                    bb  = bi % 10;
                    if (bb == 0)      exTx = 1'b0;
                    else if (bb == 9) exTx = 1'b1;
                    else              exTx = curFrame[8 * by + bb - 1];
                end
                if (txL !== exTx || busyL !== mBusy || fcL !== mCount) begin
                    if (segErr == 0) firstBad = cyc;
                    segErr++;
                end
            end
        end

        // Monitor: decode the line into frames and score them.
        initial begin : decoder
            bit          inByte, r;
            int          byteStart, frameStart, prevStart, nBytes, off, b;
            logic [7:0]  sh;
            logic [63:0] got;
            frame_t      e;
            inByte = 0; nBytes = 0; byteStart = 0; frameStart = 0; prevStart = 0;
            sh = '0; got = '0;
            forever begin
                @(posedge clk);
                r = rst;
                #2;
                if (r) begin
                    inByte = 0;
                    nBytes = 0;
                end else if (!inByte) begin
                    if (txL === 1'b0) begin
                        inByte    = 1;
                        byteStart = cyc;
                        if (nBytes == 0) frameStart = cyc;
                        else check($sformatf("lane%0d byte spacing", g), 64'(cyc - prevStart), 64'(10 * C));
                    end
                end else begin
                    off = cyc - byteStart;
                    if (off % C == C / 2) begin
                        b = off / C;
                        if (b >= 1 && b <= 8) begin
                            sh[b - 1] = txL;
                        end else if (b == 9) begin
                            check($sformatf("lane%0d stop bit", g), 64'(txL), 64'd1);
                            got[8 * nBytes +: 8] = sh;
                            nBytes++;
                            prevStart = byteStart;
                            inByte    = 0;
                            if (nBytes == 8) begin
                                nBytes = 0;
                                check($sformatf("lane%0d frame was expected", g), 64'(expQ.size() > 0), 64'd1);
                                if (expQ.size() > 0) begin
                                    e = expQ.pop_front();
                                    check($sformatf("lane%0d frame bytes", g), got, e.bytes);
                                    check($sformatf("lane%0d frame start cycle", g), 64'(frameStart), 64'(e.start));
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic waitIdle(input string what);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 4000) begin
            @(negedge clk);
            n++;
            if (!lane[0].busyL && !lane[1].busyL && !lane[2].busyL &&
                !lane[0].mBusy && !lane[1].mBusy && !lane[2].mBusy) quiet++;
            else quiet = 0;
        end
        check({"settle within cycle budget: ", what}, 64'(quiet >= 3), 64'd1);
    endtask

    task automatic pulseForce();
        printForce = 1'b1;
        @(negedge clk);
        printForce = 1'b0;
    endtask

    initial begin
        rst = 1'b1; r1 = '0; r2 = '0; r3 = '0; printForce = 1'b0; holdForce = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset tx", 64'(lane[1].txL), 64'd1);
        check("reset busy", 64'(lane[1].busyL), 64'd0);
        check("reset frameCount", 64'(lane[1].fcL), 64'd0);

        // Unchanged zero inputs: line must stay idle.
        repeat (1000) @(negedge clk);

        // One forced frame of zeros.
        pulseForce();
        waitIdle("forced zero frame");

        // Directed values: A5 12 34 AB CD 00 01 41.
        r1 = 16'h1234; r2 = 16'hABCD; r3 = 16'h0001;
        waitIdle("directed frame");

        // Changes during a frame coalesce into one follow-up frame.
        r1 = 16'h0001;
        repeat (20) @(negedge clk);
        r1 = 16'h0002;
        repeat (50) @(negedge clk);
        r1 = 16'h0003;
        waitIdle("coalesced frames");

        // Reset during byte 3 of the CLKS_PER_BIT=4 lane, then a fresh frame.
        r2 = 16'h5555;
        repeat (130) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitIdle("frame after reset");

        // Randomized changes and forces at random spacing.
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: r1 = 16'($urandom);
                1: r2 = 16'($urandom);
                2: r3 = 16'($urandom);
                default: pulseForce();
            endcase
            repeat ($urandom_range(0, 1200)) @(negedge clk);
        end
        waitIdle("random phase");

        // 256 back-to-back forced frames on the fastest lane: counter wraps.
        holdForce[0] = 1'b1;
        repeat (256 * (80 * 2 + 1)) @(negedge clk);
        holdForce[0] = 1'b0;
        waitIdle("wrap phase");

        for (int g = 0; g < 3; g++) begin
            case (g)
                0: check("lane0 scoreboard drained", 64'(lane[0].expQ.size()), 64'd0);
                1: check("lane1 scoreboard drained", 64'(lane[1].expQ.size()), 64'd0);
                default: check("lane2 scoreboard drained", 64'(lane[2].expQ.size()), 64'd0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
        $finish;
    end

endmodule
